// File: rtl/csa_pkg.sv
// Shared types and sizing helpers for the carry-save accumulator controller.
package csa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    OUTPUT
  } state_t;

  localparam int DEFAULT_W       = 4;
  localparam int DEFAULT_MAX_OPS = 16;

  // acc_width: a sum of up to max_ops w-bit operands never overflows this width.
  function automatic int acc_width(input int w, input int max_ops);
    return w + $clog2(max_ops);
  endfunction

  function automatic int cnt_width(input int max_ops);
    return $clog2(max_ops + 1);
  endfunction

endpackage

// File: rtl/csa_row.sv
// One row of N full adders used as a 3:2 compressor; carries are returned unshifted.
module csa_row #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] s,
  output logic [N-1:0] cy
);

  always_comb begin
    s  = a ^ b ^ c;
    cy = (a & b) | (a & c) | (b & c);
  end

endmodule

// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator keeping a redundant sum/carry total, resolved once per group.
// Define CSA_ERR_EN to add the out_err port flagging groups cut off at MAX_OPS.
module csa_accum_ctrl
  import csa_pkg::*;
#(
  parameter int W       = DEFAULT_W,
  parameter int MAX_OPS = DEFAULT_MAX_OPS,
  localparam int ACC_W  = acc_width(W, MAX_OPS),
  localparam int CW     = cnt_width(MAX_OPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CW-1:0]    out_count,
  output logic             busy
`ifdef CSA_ERR_EN
  ,
  output logic             out_err
`endif
);

  state_t state;
  state_t next_state;

  logic [ACC_W-1:0] sum_r;
  logic [ACC_W-1:0] carry_r;
  logic [CW-1:0]    cnt_r;
  logic [ACC_W-1:0] op_ext;
  logic [ACC_W-1:0] row_s;
  logic [ACC_W-1:0] row_cy;
  logic             accept;
  logic             at_limit;

  assign accept   = in_valid & in_ready;
  assign op_ext   = {{(ACC_W-W){1'b0}}, in_data};
  assign at_limit = (cnt_r == CW'(MAX_OPS - 1));

  csa_row #(
    .N(ACC_W)
  ) u_row (
    .a (sum_r),
    .b (carry_r),
    .c (op_ext),
    .s (row_s),
    .cy(row_cy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // The operand that reaches MAX_OPS closes the group even without in_last.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = in_last ? RESOLVE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept && (in_last || at_limit)) begin
          next_state = RESOLVE;
        end
      end
      RESOLVE: begin
        next_state = OUTPUT;
      end
      OUTPUT: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) || (state == ACCUM);
    out_valid = (state == OUTPUT);
    busy      = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r     <= '0;
      carry_r   <= '0;
      cnt_r     <= '0;
      out_sum   <= '0;
      out_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sum_r   <= op_ext;
            carry_r <= '0;
            cnt_r   <= CW'(1);
          end
        end
        ACCUM: begin
          if (accept) begin
            sum_r   <= row_s;
            carry_r <= row_cy << 1;
            cnt_r   <= cnt_r + CW'(1);
          end
        end
        RESOLVE: begin
          out_sum   <= sum_r + carry_r;
          out_count <= cnt_r;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CSA_ERR_EN
  logic forced_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      forced_r <= 1'b0;
      out_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            forced_r <= 1'b0;
          end
        end
        ACCUM: begin
          if (accept) begin
            forced_r <= at_limit & ~in_last;
          end
        end
        RESOLVE: begin
          out_err <= forced_r;
        end
        default: begin
        end
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Directed self-checking bench for csa_accum_ctrl at W=4, MAX_OPS=16 (ACC_W=8, CW=5).
module tb_csa_accum_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic [4:0] out_count;
  logic       busy;
`ifdef CSA_ERR_EN
  logic       out_err;
`endif

  int checks = 0;
  int errors = 0;

  csa_accum_ctrl #(
    .W(4),
    .MAX_OPS(16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count),
    .busy     (busy)
`ifdef CSA_ERR_EN
    ,
    .out_err  (out_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one operand and returns just after the edge that accepted it.
  task automatic applyStimulus(input logic [3:0] d, input logic last);
    int waits;
    waits    = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && waits < 50) begin
      tick(1);
      waits++;
    end
    if (waits >= 50) checkOutput("in_ready_timeout", 32'(waits), 0);
    tick(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic getResult(input string tag, input int exp_sum, input int exp_cnt,
                           input logic exp_err, input int stall);
    int waits;
    waits = 0;
    while (!out_valid && waits < 50) begin
      tick(1);
      waits++;
    end
    if (waits >= 50) checkOutput({tag, "_valid_timeout"}, 32'(waits), 0);
    for (int i = 0; i < stall; i++) begin
      checkOutput({tag, "_stall_valid"}, 32'(out_valid), 1);
      checkOutput({tag, "_stall_sum"}, 32'(out_sum), 32'(exp_sum));
      checkOutput({tag, "_stall_count"}, 32'(out_count), 32'(exp_cnt));
      checkOutput({tag, "_stall_in_ready"}, 32'(in_ready), 0);
      checkOutput({tag, "_stall_busy"}, 32'(busy), 1);
      tick(1);
    end
    checkOutput({tag, "_sum"}, 32'(out_sum), 32'(exp_sum));
    checkOutput({tag, "_count"}, 32'(out_count), 32'(exp_cnt));
`ifdef CSA_ERR_EN
    checkOutput({tag, "_err"}, 32'(out_err), 32'(exp_err));
`else
    if (exp_err) $display("[TB] %s expects a forced-termination flag (port not built)", tag);
`endif
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    checkOutput({tag, "_post_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_post_busy"}, 32'(busy), 0);
    checkOutput({tag, "_post_in_ready"}, 32'(in_ready), 1);
    checkOutput({tag, "_post_sum_kept"}, 32'(out_sum), 32'(exp_sum));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    tick(2);
    checkOutput("reset_out_valid", 32'(out_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_in_ready", 32'(in_ready), 1);
    checkOutput("reset_out_sum", 32'(out_sum), 0);
    checkOutput("reset_out_count", 32'(out_count), 0);
    rst_n = 1'b1;
    tick(1);

    $display("[TB] single operand group");
    applyStimulus(4'd9, 1'b1);
    checkOutput("t1_valid_T1", 32'(out_valid), 0);
    checkOutput("t1_in_ready_resolve", 32'(in_ready), 0);
    checkOutput("t1_busy_resolve", 32'(busy), 1);
    tick(1);
    checkOutput("t1_valid_T2", 32'(out_valid), 1);
    getResult("t1", 9, 1, 1'b0, 0);

    $display("[TB] back-to-back 15,15,15");
    applyStimulus(4'd15, 1'b0);
    applyStimulus(4'd15, 1'b0);
    applyStimulus(4'd15, 1'b1);
    checkOutput("t2_in_ready_resolve", 32'(in_ready), 0);
    tick(1);
    checkOutput("t2_in_ready_output", 32'(in_ready), 0);
    getResult("t2", 45, 3, 1'b0, 0);

    $display("[TB] forced termination at 16 operands");
    for (int i = 0; i < 16; i++) applyStimulus(4'd15, 1'b0);
    checkOutput("t3_busy_after_16", 32'(busy), 1);
    checkOutput("t3_in_ready_after_16", 32'(in_ready), 0);
    getResult("t3", 240, 16, 1'b1, 0);
    applyStimulus(4'd5, 1'b1);
    getResult("t3b", 5, 1, 1'b0, 0);

    // An operand offered while the result is pending must wait for IDLE.
    $display("[TB] output stall with pending operand");
    applyStimulus(4'd6, 1'b0);
    applyStimulus(4'd10, 1'b1);
    in_valid = 1'b1;
    in_data  = 4'd2;
    in_last  = 1'b1;
    getResult("t4", 16, 2, 1'b0, 5);
    tick(1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    checkOutput("t4b_busy_after_accept", 32'(busy), 1);
    getResult("t4b", 2, 1, 1'b0, 0);

    $display("[TB] reset mid-group");
    applyStimulus(4'd7, 1'b0);
    applyStimulus(4'd8, 1'b0);
    rst_n = 1'b0;
    #1;
    checkOutput("t5_rst_out_valid", 32'(out_valid), 0);
    checkOutput("t5_rst_busy", 32'(busy), 0);
    checkOutput("t5_rst_out_sum", 32'(out_sum), 0);
    checkOutput("t5_rst_out_count", 32'(out_count), 0);
    tick(1);
    rst_n = 1'b1;
    tick(2);
    checkOutput("t5_no_result", 32'(out_valid), 0);
    applyStimulus(4'd3, 1'b0);
    applyStimulus(4'd4, 1'b1);
    getResult("t5", 7, 2, 1'b0, 0);

    $display("[TB] groups with input gaps");
    applyStimulus(4'd1, 1'b0);
    tick(2);
    applyStimulus(4'd2, 1'b0);
    tick(1);
    applyStimulus(4'd3, 1'b1);
    getResult("t6a", 6, 3, 1'b0, 2);
    applyStimulus(4'd12, 1'b0);
    tick(3);
    checkOutput("t6_gap_hold_busy", 32'(busy), 1);
    applyStimulus(4'd13, 1'b0);
    applyStimulus(4'd14, 1'b0);
    applyStimulus(4'd11, 1'b1);
    getResult("t6b", 50, 4, 1'b0, 1);
    for (int i = 0; i < 15; i++) applyStimulus(4'(i), 1'b0);
    applyStimulus(4'd15, 1'b1);
    getResult("t6c", 120, 16, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit");
  end

endmodule
